// File: rtl/qsn_pkg.sv
// Shared definitions for the QSN cyclic shifter: direction encodings, lane slicing, shift range check.
// Latency: none, this package holds only constants and pure functions.
// Backpressure: not applicable.
package qsn_pkg;

  localparam logic QSN_LEFT  = 1'b0;
  localparam logic QSN_RIGHT = 1'b1;

  // Bit offset of a lane inside the flattened Z*MSG_W message bus.
  function automatic int lane_lsb(input int lane, input int msg_w);
    return lane * msg_w;
  endfunction

  // A shift of Z or more has no defined rotation and is flagged as an error.
  function automatic logic shift_oob(input int unsigned shift, input int unsigned z);
    return shift >= z;
  endfunction

endpackage

// File: rtl/qsn_rot_stage.sv
// One QSN mux stage: conditionally rotates all lanes by ROT in the beat's direction, then registers.
// Latency: 1 cycle; the register also carries valid, shift, dir and err alongside the data.
// Backpressure: loads only when adv is high, otherwise holds everything (bubbles included).
// Ports: sys_clk/rstn; adv enable; in_* beat from the previous stage; out_* registered beat.
module qsn_rot_stage
  import qsn_pkg::*;
#(
  parameter int Z       = 5,
  parameter int MSG_W   = 4,
  parameter int SHIFT_W = 3,
  parameter int K       = 0,
  parameter int ROT     = 1
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  input  logic                 adv,
  input  logic                 in_valid,
  input  logic [Z*MSG_W-1:0]   in_msg,
  input  logic [SHIFT_W-1:0]   in_shift,
  input  logic                 in_dir,
  input  logic                 in_err,
  output logic                 out_valid,
  output logic [Z*MSG_W-1:0]   out_msg,
  output logic [SHIFT_W-1:0]   out_shift,
  output logic                 out_dir,
  output logic                 out_err
);

  logic [Z*MSG_W-1:0] rot_left;
  logic [Z*MSG_W-1:0] rot_right;
  logic [Z*MSG_W-1:0] rot_msg;

  // Both rotations are fixed wiring; only the final select is real logic.
  for (genvar i = 0; i < Z; i++) begin : g_lane
    localparam int SRC_L = (i + ROT) % Z;
    localparam int SRC_R = (i + Z - ROT) % Z;
    assign rot_left[lane_lsb(i, MSG_W) +: MSG_W]  = in_msg[lane_lsb(SRC_L, MSG_W) +: MSG_W];
    assign rot_right[lane_lsb(i, MSG_W) +: MSG_W] = in_msg[lane_lsb(SRC_R, MSG_W) +: MSG_W];
  end

  always_comb begin
    rot_msg = in_msg;
    if (in_shift[K]) begin
      rot_msg = (in_dir == QSN_RIGHT) ? rot_right : rot_left;
    end
  end

  // Data is loaded even on bubbles; it is don't-care whenever valid is low.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_msg   <= '0;
      out_shift <= '0;
      out_dir   <= QSN_LEFT;
      out_err   <= 1'b0;
    end else if (adv) begin
      out_valid <= in_valid;
      out_msg   <= rot_msg;
      out_shift <= in_shift;
      out_dir   <= in_dir;
      out_err   <= in_err;
    end
  end

endmodule

// File: rtl/qsn_cyclic_shift_pipe.sv
// Pipelined Z-lane cyclic shifter (left/right per beat) for QC-LDPC message routing.
// Latency: SHIFT_W cycles from acceptance to out_valid, one beat per cycle.
// Backpressure: global stall, in_ready = !out_valid || out_ready; all stages hold together when stalled.
// Ports: sys_clk/rstn; in_valid/in_ready/in_msg/in_shift/in_dir input beat; out_valid/out_ready/out_msg/out_err output beat.
module qsn_cyclic_shift_pipe
  import qsn_pkg::*;
#(
  parameter int Z       = 5,
  parameter int MSG_W   = 4,
  parameter int SHIFT_W = $clog2(Z)
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Z*MSG_W-1:0]   in_msg,
  input  logic [SHIFT_W-1:0]   in_shift,
  input  logic                 in_dir,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Z*MSG_W-1:0]   out_msg,
  output logic                 out_err
);

  logic                              adv;
  logic                              in_err;
  logic [SHIFT_W-1:0]                shift_eff;

  // Element k is the input of stage k; element SHIFT_W is the pipe output.
  logic [SHIFT_W:0]                  valid_chain;
  logic [SHIFT_W:0]                  dir_chain;
  logic [SHIFT_W:0]                  err_chain;
  logic [SHIFT_W:0][Z*MSG_W-1:0]     msg_chain;
  logic [SHIFT_W:0][SHIFT_W-1:0]     shift_chain;
  logic                              unused_shift;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Out-of-range shifts travel as zero so every stage passes the data straight through.
  assign in_err    = shift_oob(32'(in_shift), Z);
  assign shift_eff = in_err ? '0 : in_shift;

  assign valid_chain[0] = in_valid;
  assign msg_chain[0]   = in_msg;
  assign shift_chain[0] = shift_eff;
  assign dir_chain[0]   = in_dir;
  assign err_chain[0]   = in_err;

  for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
    localparam int ROT_K = (1 << k) % Z;
    qsn_rot_stage #(
      .Z       (Z),
      .MSG_W   (MSG_W),
      .SHIFT_W (SHIFT_W),
      .K       (k),
      .ROT     (ROT_K)
    ) u_stage (
      .sys_clk   (sys_clk),
      .rstn      (rstn),
      .adv       (adv),
      .in_valid  (valid_chain[k]),
      .in_msg    (msg_chain[k]),
      .in_shift  (shift_chain[k]),
      .in_dir    (dir_chain[k]),
      .in_err    (err_chain[k]),
      .out_valid (valid_chain[k+1]),
      .out_msg   (msg_chain[k+1]),
      .out_shift (shift_chain[k+1]),
      .out_dir   (dir_chain[k+1]),
      .out_err   (err_chain[k+1])
    );
  end

  assign out_valid = valid_chain[SHIFT_W];
  assign out_msg   = msg_chain[SHIFT_W];
  assign out_err   = err_chain[SHIFT_W];

  // The shift and direction have no consumer after the last stage.
  assign unused_shift = ^shift_chain[SHIFT_W] ^ dir_chain[SHIFT_W];

endmodule

// File: tb/tb_qsn_cyclic_shift_pipe.sv
// Self-checking bench for qsn_cyclic_shift_pipe: Z=5 directed/stream/stall/reset tests plus Z=8 and Z=26 sweeps.
// Expected beats come from a lane-array rotate model and a queue scoreboard.
module tb_qsn_cyclic_shift_pipe;

  localparam int Z  = 5;
  localparam int MW = 4;
  localparam int SW = 3;
  localparam int W  = Z * MW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_msg;
  logic [SW-1:0] in_shift;
  logic          in_dir;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_msg;
  logic          out_err;

  // Shared stimulus for the two sweep instances; sel picks the active one.
  int            sel;
  logic          sw_valid;
  logic [103:0]  sw_msg;
  logic [4:0]    sw_shift;
  logic          sw_dir;
  logic          sw_ready;
  logic          o8_ready, o8_valid, o8_err;
  logic [31:0]   o8_msg;
  logic          o26_ready, o26_valid, o26_err;
  logic [103:0]  o26_msg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [103:0] msg;
    logic         err;
  } exp_t;
  exp_t exp_q[$];

  qsn_cyclic_shift_pipe #(.Z(Z), .MSG_W(MW)) dut (
    .sys_clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg), .in_shift(in_shift), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg), .out_err(out_err)
  );

  qsn_cyclic_shift_pipe #(.Z(8), .MSG_W(MW)) dut8 (
    .sys_clk(clk), .rstn(rstn),
    .in_valid(sw_valid && (sel == 8)), .in_ready(o8_ready), .in_msg(sw_msg[31:0]),
    .in_shift(sw_shift[2:0]), .in_dir(sw_dir),
    .out_valid(o8_valid), .out_ready(sw_ready), .out_msg(o8_msg), .out_err(o8_err)
  );

  qsn_cyclic_shift_pipe #(.Z(26), .MSG_W(MW)) dut26 (
    .sys_clk(clk), .rstn(rstn),
    .in_valid(sw_valid && (sel == 26)), .in_ready(o26_ready), .in_msg(sw_msg),
    .in_shift(sw_shift), .in_dir(sw_dir),
    .out_valid(o26_valid), .out_ready(sw_ready), .out_msg(o26_msg), .out_err(o26_err)
  );

  // Reference: out lane i = in lane (i+s) mod z (left) or (i-s+z) mod z (right); s >= z means no rotation.
  function automatic logic [103:0] ref_rotate(input logic [103:0] m, input int s, input logic dir, input int z);
    logic [103:0] r;
    int eff;
    int src;
    r   = '0;
    eff = (s >= z) ? 0 : s;
    for (int i = 0; i < z; i++) begin
      src = dir ? (i - eff + z) % z : (i + eff) % z;
      for (int b = 0; b < MW; b++) r[i*MW + b] = m[src*MW + b];
    end
    return r;
  endfunction

  // Drive one cycle on the Z=5 instance and sample just after the falling edge.
  task automatic step(input logic v, input logic [W-1:0] m, input logic [SW-1:0] s, input logic d,
                      input logic r, output logic acc, output logic got,
                      output logic [W-1:0] om, output logic oe);
    @(negedge clk);
    in_valid  = v;
    in_msg    = m;
    in_shift  = s;
    in_dir    = d;
    out_ready = r;
    #1;
    acc = in_valid && in_ready;
    got = out_valid && out_ready;
    om  = out_msg;
    oe  = out_err;
    if (acc) exp_q.push_back('{msg: ref_rotate({84'b0, m}, int'(s), d, Z), err: (int'(s) >= Z)});
  endtask

  task automatic test_reset;
    rstn = 1'b1;
    in_valid = 1'b0; in_msg = '0; in_shift = '0; in_dir = 1'b0; out_ready = 1'b1;
    sel = 0; sw_valid = 1'b0; sw_msg = '0; sw_shift = '0; sw_dir = 1'b0; sw_ready = 1'b1;
    #1 rstn = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_msg !== '0) begin errors++; $display("FAIL reset_out_msg got=%h want=0", out_msg); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%b want=0", out_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_directed;
    logic [SW-1:0] sh   [8] = '{3'd2, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd0};
    logic          dr   [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0]  want [8] = '{20'h10432, 20'h32104, 20'h32104, 20'h43210,
                                20'h43210, 20'h43210, 20'h43210, 20'h43210};
    logic          werr [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic acc, got, oe, seen;
    logic [W-1:0] om, seen_msg;
    logic seen_err;
    int lat;
    for (int t = 0; t < 8; t++) begin
      step(1'b1, 20'h43210, sh[t], dr[t], 1'b1, acc, got, om, oe);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL dir%0d_accept got=%b want=1", t, acc); end
      seen = 1'b0; lat = 0; seen_msg = '0; seen_err = 1'b0;
      while (!seen && lat < 10) begin
        step(1'b0, '0, '0, 1'b0, 1'b1, acc, got, om, oe);
        lat++;
        if (got) begin seen = 1'b1; seen_msg = om; seen_err = oe; end
      end
      checks++; if (!seen || lat != SW) begin errors++; $display("FAIL dir%0d_latency got=%0d seen=%b want=%0d", t, lat, seen, SW); end
      checks++; if (seen_msg !== want[t]) begin errors++; $display("FAIL dir%0d_msg got=%h want=%h", t, seen_msg, want[t]); end
      checks++; if (seen_err !== werr[t]) begin errors++; $display("FAIL dir%0d_err got=%b want=%b", t, seen_err, werr[t]); end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    logic acc, got, oe;
    logic [W-1:0] om;
    exp_t e;
    int i, rx, first, last;
    i = 0; rx = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      step(i < 8, 20'($urandom), 3'(i % 5), 1'(i & 1), 1'b1, acc, got, om, oe);
      if (acc) i++;
      if (got) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_extra_beat got=%h want=none", om);
        end else begin
          e = exp_q.pop_front();
          checks++; if (om !== e.msg[W-1:0]) begin errors++; $display("FAIL b2b_msg%0d got=%h want=%h", rx, om, e.msg[W-1:0]); end
          checks++; if (oe !== e.err) begin errors++; $display("FAIL b2b_err%0d got=%b want=%b", rx, oe, e.err); end
        end
        if (first < 0) first = cyc;
        last = cyc;
        rx++;
      end
    end
    checks++; if (rx != 8) begin errors++; $display("FAIL b2b_count got=%0d want=8", rx); end
    checks++; if (last - first != 7) begin errors++; $display("FAIL b2b_span got=%0d want=7", last - first); end
    exp_q.delete();
  endtask

  task automatic test_backpressure;
    logic [W-1:0]  bm [6];
    logic [SW-1:0] bs [6];
    logic          bd [6];
    logic acc, got, oe, se;
    logic [W-1:0] om, sm;
    exp_t e;
    int i, rx;
    for (int k = 0; k < 6; k++) begin
      bm[k] = 20'($urandom); bs[k] = 3'($urandom_range(0, 4)); bd[k] = 1'($urandom);
    end
    i = 0; rx = 0;
    for (int k = 0; k < 10 && !out_valid; k++) begin
      step(i < 6, bm[i % 6], bs[i % 6], bd[i % 6], 1'b0, acc, got, om, oe);
      if (acc) i++;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_fill got=%b want=1", out_valid); end
    sm = out_msg; se = out_err;
    for (int k = 0; k < 4; k++) begin
      step(i < 6, bm[i % 6], bs[i % 6], bd[i % 6], 1'b0, acc, got, om, oe);
      if (acc) i++;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got=%b want=0", k, in_ready); end
      checks++; if (om !== sm || oe !== se || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d got=%h/%b/%b want=%h/%b/1", k, om, oe, out_valid, sm, se);
      end
    end
    for (int k = 0; k < 40 && (rx < 6 || i < 6); k++) begin
      step(i < 6, bm[i % 6], bs[i % 6], bd[i % 6], 1'b1, acc, got, om, oe);
      if (acc) i++;
      if (got) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL bp_extra_beat got=%h want=none", om);
        end else begin
          e = exp_q.pop_front();
          checks++; if (om !== e.msg[W-1:0] || oe !== e.err) begin
            errors++; $display("FAIL bp_drain%0d got=%h/%b want=%h/%b", rx, om, oe, e.msg[W-1:0], e.err);
          end
        end
        rx++;
      end
    end
    checks++; if (rx != 6) begin errors++; $display("FAIL bp_count got=%0d want=6", rx); end
    exp_q.delete();
  endtask

  task automatic test_reset_midop;
    logic acc, got, oe, seen;
    logic [W-1:0] om;
    int lat, stale;
    step(1'b1, 20'h12345, 3'd1, 1'b0, 1'b0, acc, got, om, oe);
    step(1'b1, 20'h6789a, 3'd2, 1'b1, 1'b0, acc, got, om, oe);
    step(1'b0, '0, '0, 1'b0, 1'b0, acc, got, om, oe);
    step(1'b0, '0, '0, 1'b0, 1'b0, acc, got, om, oe);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%b want=1", out_valid); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got=%b want=0", out_valid); end
    checks++; if (out_msg !== '0) begin errors++; $display("FAIL rst_async_msg got=%h want=0", out_msg); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready got=%b want=1", in_ready); end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    stale = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, acc, got, om, oe);
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rst_stale_beats got=%0d want=0", stale); end
    step(1'b1, 20'h43210, 3'd3, 1'b1, 1'b1, acc, got, om, oe);
    seen = 1'b0; lat = 0;
    while (!seen && lat < 10) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, acc, got, om, oe);
      lat++;
      if (got) seen = 1'b1;
    end
    checks++; if (!seen || lat != SW) begin errors++; $display("FAIL rst_new_latency got=%0d want=%0d", lat, SW); end
    checks++; if (om !== 20'h10432) begin errors++; $display("FAIL rst_new_msg got=%h want=10432", om); end
    exp_q.delete();
  endtask

  task automatic test_sweep(input int z);
    int zw, n, sent, rx, errs_seen;
    logic [103:0] mask, cur_msg, om;
    logic [4:0] cur_sh;
    logic cur_dir, ov, ordy, oe;
    exp_t e;
    zw = $clog2(z);
    n = 60; sent = 0; rx = 0; errs_seen = 0;
    mask = '0;
    for (int b = 0; b < z*MW; b++) mask[b] = 1'b1;
    sel = z;
    cur_msg = {$urandom, $urandom, $urandom, $urandom} & mask;
    cur_sh  = 5'($urandom_range(0, (1 << zw) - 1));
    cur_dir = 1'($urandom);
    for (int cyc = 0; cyc < 2000 && rx < n; cyc++) begin
      @(negedge clk);
      sw_valid = (sent < n) && ($urandom_range(0, 3) != 0);
      sw_msg   = cur_msg;
      sw_shift = cur_sh;
      sw_dir   = cur_dir;
      sw_ready = ($urandom_range(0, 9) < 7);
      #1;
      ov   = (z == 8) ? o8_valid : o26_valid;
      ordy = (z == 8) ? o8_ready : o26_ready;
      om   = (z == 8) ? {72'b0, o8_msg} : o26_msg;
      oe   = (z == 8) ? o8_err : o26_err;
      if (sw_valid && ordy) begin
        exp_q.push_back('{msg: ref_rotate(cur_msg, int'(cur_sh), cur_dir, z), err: (int'(cur_sh) >= z)});
        sent++;
        cur_msg = {$urandom, $urandom, $urandom, $urandom} & mask;
        cur_sh  = 5'($urandom_range(0, (1 << zw) - 1));
        cur_dir = 1'($urandom);
      end
      if (ov && sw_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL sweep%0d_extra_beat got=%h want=none", z, om);
        end else begin
          e = exp_q.pop_front();
          if (e.err) errs_seen++;
          checks++; if (om !== e.msg) begin errors++; $display("FAIL sweep%0d_msg%0d got=%h want=%h", z, rx, om, e.msg); end
          checks++; if (oe !== e.err) begin errors++; $display("FAIL sweep%0d_err%0d got=%b want=%b", z, rx, oe, e.err); end
        end
        rx++;
      end
    end
    sw_valid = 1'b0;
    checks++; if (rx != n) begin errors++; $display("FAIL sweep%0d_count got=%0d want=%0d", z, rx, n); end
    exp_q.delete();
    $display("sweep z=%0d: %0d beats, %0d out-of-range", z, rx, errs_seen);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    test_sweep(8);
    test_sweep(26);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
